sevenseg_scan: RTL and testbench

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It sits directly downstream of the clock divider: the divider's toggling output enters as `scan_clk`, is synchronized into the `clk_in` domain, and each rising edge advances the active digit. It decodes one hex nibble of a 16-bit value per digit, with optional leading-zero blanking and per-digit decimal points. All outputs are registered.

---
 rtl/sevenseg_scan.sv | 117 +++++++++++
 tb/tb_sevenseg_scan.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// A synchronized scan_clk rising edge advances the digit and reloads all registered outputs.
module sevenseg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        scan_clk,
    input  logic        en,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_sel
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   adv;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic [3:0] nibble;
    logic       blankDigit;

    function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
        logic [6:0] pattern;
        case (nib)
            4'h0: pattern = 7'h40;
            4'h1: pattern = 7'h79;
            4'h2: pattern = 7'h24;
            4'h3: pattern = 7'h30;
            4'h4: pattern = 7'h19;
            4'h5: pattern = 7'h12;
            4'h6: pattern = 7'h02;
            4'h7: pattern = 7'h78;
            4'h8: pattern = 7'h00;
            4'h9: pattern = 7'h10;
            4'hA: pattern = 7'h08;
            4'hB: pattern = 7'h03;
            4'hC: pattern = 7'h46;
            4'hD: pattern = 7'h21;
            4'hE: pattern = 7'h06;
            default: pattern = 7'h0E;
        endcase
        return pattern;
    endfunction

    // scan_clk is only ever sampled as data; prev_q turns its rising edge into a one-cycle pulse.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], scan_clk};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign adv = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        idx_d      = adv ? idx_q + IDX_W'(1) : idx_q;
        nibble     = value[3:0];
        blankDigit = 1'b0;
        case (idx_d)
            2'd0: begin
                nibble     = value[3:0];
                blankDigit = 1'b0;
            end
            2'd1: begin
                nibble     = value[7:4];
                blankDigit = blank_lz && (value[15:4] == 12'h000);
            end
            2'd2: begin
                nibble     = value[11:8];
                blankDigit = blank_lz && (value[15:8] == 8'h00);
            end
            default: begin
                nibble     = value[15:12];
                blankDigit = blank_lz && (value[15:12] == 4'h0);
            end
        endcase
        an_d  = en ? ~(4'b0001 << idx_d) : 4'b1111;
        seg_d = blankDigit ? 7'h7F : hexToSeg(nibble);
        dp_d  = ~dp_in[idx_d];
    end

    // Inputs are only looked at on adv, so changes between advances never reach the display.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= IDX_W'(NUM_DIGITS - 1);
            an_q  <= 4'b1111;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else if (adv) begin
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign digit_sel = idx_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan: directed and randomized scans compared
// against a digit-level model of the display.
module tb_sevenseg_scan;

    logic        clk_in;
    logic        rst_n;
    logic        scan_clk;
    logic        en;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_sel;

    int testCount = 0;
    int failCount = 0;

    int         expIdx;
    logic [3:0] expAn;
    logic [6:0] expSeg;
    logic       expDp;
    logic [1:0] expSel;

    logic [6:0] segTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    sevenseg_scan #(.NUM_DIGITS(4), .SYNC_STAGES(2)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .scan_clk  (scan_clk),
        .en        (en),
        .value     (value),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .digit_sel (digit_sel)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic resetModel();
        expIdx = 3;
        expAn  = 4'b1111;
        expSeg = 7'h7F;
        expDp  = 1'b1;
        expSel = 2'd3;
    endtask

    // One advance of the display as seen from outside: next digit, decoded from the current inputs.
    task automatic advanceModel();
        int upper;
        expIdx = (expIdx + 1) % 4;
        upper  = int'(value) >> (4 * expIdx);
        if (blank_lz && expIdx > 0 && upper == 0)
            expSeg = 7'h7F;
        else
            expSeg = segTable[upper % 16];
        expAn  = en ? (4'b1111 & ~(4'b0001 << expIdx)) : 4'b1111;
        expDp  = !dp_in[expIdx];
        expSel = 2'(expIdx);
    endtask

    task automatic checkOutput(input string tag);
        testCount++;
        assert (an === expAn) else begin
            failCount++;
            $error("[TB] FAIL %s an: got %b want %b", tag, an, expAn);
        end
        testCount++;
        assert (seg === expSeg) else begin
            failCount++;
            $error("[TB] FAIL %s seg: got %h want %h", tag, seg, expSeg);
        end
        testCount++;
        assert (dp === expDp) else begin
            failCount++;
            $error("[TB] FAIL %s dp: got %b want %b", tag, dp, expDp);
        end
        testCount++;
        assert (digit_sel === expSel) else begin
            failCount++;
            $error("[TB] FAIL %s digit_sel: got %0d want %0d", tag, digit_sel, expSel);
        end
    endtask

    // One scan_clk period: outputs must hold for two edges after the rise and change on the third.
    task automatic applyStimulus(input string tag, input int highCycles, input int lowCycles);
        @(negedge clk_in);
        scan_clk = 1'b1;
        @(posedge clk_in);
        @(posedge clk_in);
        @(negedge clk_in);
        checkOutput({tag, "_before"});
        @(posedge clk_in);
        @(negedge clk_in);
        advanceModel();
        checkOutput({tag, "_after"});
        repeat (highCycles - 3) @(negedge clk_in);
        scan_clk = 1'b0;
        repeat (lowCycles) @(negedge clk_in);
        checkOutput({tag, "_low"});
    endtask

    initial begin
        int lz;
        logic [1:0] selBefore;

        rst_n    = 1'b0;
        scan_clk = 1'b0;
        en       = 1'b1;
        value    = 16'h1234;
        dp_in    = 4'b0000;
        blank_lz = 1'b0;
        resetModel();
        repeat (3) @(negedge clk_in);
        checkOutput("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk_in);
        checkOutput("reset_idle");

        for (int i = 0; i < 5; i++) applyStimulus("scan_order", 4, 4);

        value    = 16'h0005;
        blank_lz = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus("blank_on", 4, 4);
        blank_lz = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus("blank_off", 4, 4);
        value    = 16'h0400;
        blank_lz = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus("blank_mid_zero", 4, 4);

        value    = 16'hABCD;
        blank_lz = 1'b0;
        dp_in    = 4'b0100;
        for (int i = 0; i < 4; i++) applyStimulus("dp", 4, 4);
        dp_in = 4'b0000;
        en    = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus("enable_off", 4, 4);
        en = 1'b1;

        value = 16'hFFFF;
        applyStimulus("latch_ffff", 4, 4);
        value = 16'h8888;
        repeat (3) @(negedge clk_in);
        checkOutput("latch_hold");
        applyStimulus("latch_8888", 4, 4);

        applyStimulus("long_high", 50, 4);

        for (int i = 0; i < 24; i++) begin
            lz       = $urandom_range(0, 4);
            value    = 16'($urandom);
            if (lz > 0) value = value & (16'hFFFF >> (4 * lz));
            dp_in    = 4'($urandom);
            blank_lz = 1'($urandom);
            en       = ($urandom_range(0, 3) != 0);
            applyStimulus("random", $urandom_range(3, 7), $urandom_range(3, 7));
        end

        // Reset in the middle of a high scan_clk phase, with no clock edge involved.
        @(negedge clk_in);
        scan_clk = 1'b1;
        @(posedge clk_in);
        #2;
        rst_n = 1'b0;
        #1;
        resetModel();
        checkOutput("mid_reset");
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        @(posedge clk_in);
        @(posedge clk_in);
        @(negedge clk_in);
        checkOutput("post_reset_hold");
        @(posedge clk_in);
        @(negedge clk_in);
        advanceModel();
        checkOutput("post_reset_adv");
        repeat (10) @(negedge clk_in);
        checkOutput("post_reset_steady");
        scan_clk = 1'b0;
        repeat (5) @(negedge clk_in);

        applyStimulus("pre_glitch", 4, 4);
        @(negedge clk_in);
        scan_clk  = 1'b1;
        repeat (8) @(negedge clk_in);
        selBefore = expSel + 2'd1;
        scan_clk  = 1'b0;
        @(negedge clk_in);
        scan_clk  = 1'b1;
        repeat (10) @(negedge clk_in);
        testCount++;
        assert (digit_sel === selBefore || digit_sel === selBefore + 2'd1) else begin
            failCount++;
            $error("[TB] FAIL glitch digit_sel: got %0d want %0d or %0d",
                   digit_sel, selBefore, selBefore + 2'd1);
        end
        scan_clk = 1'b0;
        repeat (5) @(negedge clk_in);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
